// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
// FSM encoding, byte-enable constant and the request address check.
package dmem_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_WAIT = 2'b01,
    S_RESP = 2'b10
  } state_t;

  localparam logic [3:0] BE_ALL = 4'b1111;

  // High when the byte address is not word aligned or past the last word.
  function automatic logic addr_err(
    input logic [31:0] addr,
    input logic [31:0] depth
  );
    return (addr[1:0] != 2'b00) ||
           ({2'b00, addr[31:2]} >= depth);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 32 word storage, per-byte write enable, no reset.
// Combinational read by word index, synchronous write.
module dmem_array #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [3:0]    i_be,
  input  logic [AW-1:0] i_idx,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int i = 0; i < 4; i++) begin
        if (i_be[i]) begin
          r_mem[i_idx][8*i +: 8] <= i_wdata[8*i +: 8];
        end
      end
    end
  end

  assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, fixed latency,
// then a held response until the CPU consumes it.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_we;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic [3:0]    r_be;
  logic          r_req_ready;
  logic          r_rsp_valid;
  logic          r_rsp_err;
  logic [31:0]   r_rsp_rdata;

  logic          w_err;
  logic          w_commit;
  logic          w_wr;
  logic [AW-1:0] w_idx;
  logic [31:0]   w_rdata;

  assign w_err    = addr_err(r_addr, 32'(DEPTH));
  assign w_idx    = r_addr[AW+1:2];
  assign w_commit = (r_state == S_WAIT) && (r_cnt == '0);
  assign w_wr     = w_commit && r_we && !w_err;

  dmem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .i_clk   (clk),
    .i_we    (w_wr),
    .i_be    (r_be),
    .i_idx   (w_idx),
    .i_wdata (r_wdata),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_be        <= '0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_we        <= req_we;
            r_addr      <= req_addr;
            r_wdata     <= req_wdata;
            r_be        <= req_be;
            r_cnt       <= CNT_INIT;
            r_req_ready <= 1'b0;
            r_state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_cnt == '0) begin
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= w_err;
            r_rsp_rdata <= (w_err || r_we) ? '0 : w_rdata;
            r_state     <= S_RESP;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder.
// Directed scenarios plus randomized traffic against a word-array model.
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam int DEPTH = 64;
  localparam int LAT   = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_be = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  logic [31:0] mem_m [DEPTH];

  dmem_responder #(
    .DEPTH   (DEPTH),
    .LATENCY (LAT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: a plain word array updated in request order.
  task automatic model(input logic we, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] be,
                       output logic [31:0] rd, output logic er);
    er = (a % 4 != 0) || (a / 4 >= DEPTH);
    rd = '0;
    if (!er) begin
      if (we) begin
        for (int i = 0; i < 4; i++)
          if (be[i]) mem_m[a / 4][8*i +: 8] = wd[8*i +: 8];
      end else begin
        rd = mem_m[a / 4];
      end
    end
  endtask

  // One full request/response; reports latency and the held response.
  task automatic xact(input logic we, input logic [31:0] a,
                      input logic [31:0] wd, input logic [3:0] be,
                      input logic keep_rdy,
                      output int lat, output logic [31:0] rd,
                      output logic er, output int tacc);
    int n;
    n = 0;
    while (!req_ready && n < 40) begin
      @(posedge clk); #1; n++;
    end
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = wd;
    req_be    = be;
    @(posedge clk); #1;
    tacc      = cyc;
    req_valid = 1'b0;
    req_we    = 1'($urandom);
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_be    = 4'($urandom);
    lat = 0;
    while (!rsp_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    rd = rsp_rdata;
    er = rsp_err;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = keep_rdy;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (req_ready !== 1'b1) begin
      bad++; $display("FAIL reset_req_ready got=%b want=1", req_ready);
    end
    total++;
    if (rsp_valid !== 1'b0) begin
      bad++; $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid);
    end
    total++;
    if (rsp_rdata !== 32'h0) begin
      bad++; $display("FAIL reset_rsp_rdata got=%h want=0", rsp_rdata);
    end
    total++;
    if (rsp_err !== 1'b0) begin
      bad++; $display("FAIL reset_rsp_err got=%b want=0", rsp_err);
    end
  endtask

  task automatic test_basic();
    int lat, t;
    logic [31:0] rd, mrd;
    logic er, mer;
    model(1'b1, 32'h10, 32'hDEADBEEF, BE_ALL, mrd, mer);
    xact(1'b1, 32'h10, 32'hDEADBEEF, BE_ALL, 1'b0, lat, rd, er, t);
    total++;
    if (lat !== LAT) begin
      bad++; $display("FAIL basic_store_lat got=%0d want=%0d", lat, LAT);
    end
    total++;
    if (rd !== 32'h0 || er !== 1'b0) begin
      bad++; $display("FAIL basic_store_rsp got=%h/%b want=0/0", rd, er);
    end
    model(1'b0, 32'h10, 32'h0, 4'h0, mrd, mer);
    xact(1'b0, 32'h10, 32'h0, 4'h0, 1'b0, lat, rd, er, t);
    total++;
    if (lat !== LAT) begin
      bad++; $display("FAIL basic_load_lat got=%0d want=%0d", lat, LAT);
    end
    total++;
    if (rd !== 32'hDEADBEEF || er !== 1'b0) begin
      bad++; $display("FAIL basic_load got=%h/%b want=deadbeef/0", rd, er);
    end
  endtask

  task automatic test_partial();
    int lat, t;
    logic [31:0] rd, mrd;
    logic er, mer;
    model(1'b1, 32'h20, 32'h11223344, BE_ALL, mrd, mer);
    xact(1'b1, 32'h20, 32'h11223344, BE_ALL, 1'b0, lat, rd, er, t);
    model(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, mrd, mer);
    xact(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 1'b0, lat, rd, er, t);
    total++;
    if (er !== 1'b0) begin
      bad++; $display("FAIL partial_store_err got=%b want=0", er);
    end
    model(1'b0, 32'h20, 32'h0, 4'h0, mrd, mer);
    xact(1'b0, 32'h20, 32'h0, 4'h0, 1'b0, lat, rd, er, t);
    total++;
    if (rd !== 32'h11BB33DD || er !== 1'b0) begin
      bad++; $display("FAIL partial_load got=%h/%b want=11bb33dd/0", rd, er);
    end
  endtask

  task automatic test_errors();
    int lat, t;
    logic [31:0] rd, mrd;
    logic er, mer;
    model(1'b1, 32'h0, 32'hCAFEF00D, BE_ALL, mrd, mer);
    xact(1'b1, 32'h0, 32'hCAFEF00D, BE_ALL, 1'b0, lat, rd, er, t);
    model(1'b0, 32'h13, 32'h0, 4'h0, mrd, mer);
    xact(1'b0, 32'h13, 32'h0, 4'h0, 1'b0, lat, rd, er, t);
    total++;
    if (rd !== 32'h0 || er !== 1'b1) begin
      bad++; $display("FAIL err_misaligned got=%h/%b want=0/1", rd, er);
    end
    model(1'b0, 32'(DEPTH * 4), 32'h0, 4'h0, mrd, mer);
    xact(1'b0, 32'(DEPTH * 4), 32'h0, 4'h0, 1'b0, lat, rd, er, t);
    total++;
    if (rd !== 32'h0 || er !== 1'b1) begin
      bad++; $display("FAIL err_range_load got=%h/%b want=0/1", rd, er);
    end
    model(1'b1, 32'(DEPTH * 4), 32'hFFFFFFFF, BE_ALL, mrd, mer);
    xact(1'b1, 32'(DEPTH * 4), 32'hFFFFFFFF, BE_ALL, 1'b0,
         lat, rd, er, t);
    total++;
    if (rd !== 32'h0 || er !== 1'b1 || lat !== LAT) begin
      bad++;
      $display("FAIL err_range_store got=%h/%b/%0d want=0/1/%0d",
               rd, er, lat, LAT);
    end
    xact(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, lat, rd, er, t);
    total++;
    if (rd !== 32'hCAFEF00D || er !== 1'b0) begin
      bad++; $display("FAIL err_word0 got=%h/%b want=cafef00d/0", rd, er);
    end
  endtask

  task automatic test_stall();
    int n, lat, t;
    logic [31:0] rd;
    logic er;
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 32'h10;
    req_be    = 4'h0;
    @(posedge clk); #1;
    req_we    = 1'b1;
    req_wdata = 32'h12345678;
    req_be    = BE_ALL;
    n = 0;
    while (!rsp_valid && n < 40) begin
      @(posedge clk); #1; n++;
    end
    total++;
    if (n !== LAT) begin
      bad++; $display("FAIL stall_lat got=%0d want=%0d", n, LAT);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      total++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEADBEEF ||
          req_ready !== 1'b0) begin
        bad++;
        $display("FAIL stall_hold%0d got=%b/%h/%b want=1/deadbeef/0",
                 i, rsp_valid, rsp_rdata, req_ready);
      end
    end
    rsp_ready = 1'b1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    total++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0) begin
      bad++;
      $display("FAIL stall_release got=%b/%b/%h want=1/0/0",
               req_ready, rsp_valid, rsp_rdata);
    end
    xact(1'b0, 32'h10, 32'h0, 4'h0, 1'b0, lat, rd, er, t);
    total++;
    if (rd !== 32'hDEADBEEF || er !== 1'b0) begin
      bad++; $display("FAIL stall_no_store got=%h/%b want=deadbeef/0", rd, er);
    end
  endtask

  task automatic test_reset_mid();
    int lat, t;
    logic [31:0] rd, mrd;
    logic er, mer;
    model(1'b1, 32'h40, 32'h5, BE_ALL, mrd, mer);
    xact(1'b1, 32'h40, 32'h5, BE_ALL, 1'b0, lat, rd, er, t);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'h40;
    req_wdata = 32'h99;
    req_be    = BE_ALL;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    total++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_flags got=%b/%b want=0/1", rsp_valid, req_ready);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    xact(1'b0, 32'h40, 32'h0, 4'h0, 1'b0, lat, rd, er, t);
    total++;
    if (rd !== 32'h5 || er !== 1'b0) begin
      bad++; $display("FAIL rstmid_load got=%h/%b want=5/0", rd, er);
    end
  endtask

  task automatic test_back_to_back();
    int lat, t, tprev;
    logic [31:0] rd, mrd, a, wd;
    logic er, mer, we;
    logic [3:0] be;
    for (int i = 0; i < 8; i++) begin
      wd = $urandom;
      model(1'b1, 32'(i * 4), wd, BE_ALL, mrd, mer);
      xact(1'b1, 32'(i * 4), wd, BE_ALL, 1'b0, lat, rd, er, t);
    end
    rsp_ready = 1'b1;
    tprev = 0;
    for (int i = 0; i < 8; i++) begin
      we = (i % 2 == 0);
      a  = 32'($urandom_range(0, 7) * 4);
      wd = $urandom;
      be = 4'($urandom);
      model(we, a, wd, be, mrd, mer);
      xact(we, a, wd, be, 1'b1, lat, rd, er, t);
      total++;
      if (lat !== LAT || rd !== mrd || er !== mer) begin
        bad++;
        $display("FAIL b2b%0d got=%0d/%h/%b want=%0d/%h/%b",
                 i, lat, rd, er, LAT, mrd, mer);
      end
      if (i > 0) begin
        total++;
        if (t - tprev !== LAT + 2) begin
          bad++;
          $display("FAIL b2b_gap%0d got=%0d want=%0d", i, t - tprev, LAT + 2);
        end
      end
      tprev = t;
    end
    rsp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_partial();
    test_errors();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
